// File: rtl/piano_pkg.sv
// Shared piano datapath types: key count, chord word and capture FSM states.
package piano_pkg;

  localparam int unsigned N_KEYS = 8;

  typedef logic [N_KEYS-1:0] chord_t;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } cap_state_t;

endpackage

// File: rtl/key_debounce_bit.sv
// One key: two-flop synchroniser followed by a consecutive-mismatch debounce counter.
// KEY_CHORD_GLITCH_CNT_EN adds a one-cycle pulse for every discarded mismatch episode.
module key_debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
`ifdef KEY_CHORD_GLITCH_CNT_EN
  output logic glitch,
`endif
  output logic stb
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // stb only flips after DEBOUNCE_CYCLES consecutive mismatching samples of s2
  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      stb <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= key;
      s2 <= s1;
      if (s2 == stb) begin
        cnt <= '0;
      end else if (cnt == TERM) begin
        stb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef KEY_CHORD_GLITCH_CNT_EN
  // An episode is discarded when s2 returns to stb while the counter is non-zero
  always_ff @(posedge clk) begin
    if (rst) begin
      glitch <= 1'b0;
    end else begin
      glitch <= (s2 == stb) && (cnt != '0);
    end
  end
`endif

endmodule

// File: rtl/key_chord_capture.sv
// Debounced key chord capture with a valid/ready offer of every change of the stable key set.
// KEY_CHORD_GLITCH_CNT_EN adds the saturating glitch_count output.
module key_chord_capture #(
  parameter int unsigned N_KEYS          = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] keys,
  output logic [N_KEYS-1:0] chord,
  output logic              chord_valid,
  input  logic              chord_ready,
`ifdef KEY_CHORD_GLITCH_CNT_EN
  output logic [15:0]       glitch_count,
`endif
  output logic              any_key
);

  import piano_pkg::*;

  logic [N_KEYS-1:0] stb_vec;
  logic [N_KEYS-1:0] last_sent;
  logic [N_KEYS-1:0] last_sent_next;
  logic [N_KEYS-1:0] chord_next;
  logic              chord_valid_next;
  cap_state_t        state;
  cap_state_t        state_next;

`ifdef KEY_CHORD_GLITCH_CNT_EN
  logic [N_KEYS-1:0] glitch_vec;
`endif

  for (genvar i = 0; i < int'(N_KEYS); i++) begin : g_key
    key_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk    (clk),
      .rst    (rst),
      .key    (keys[i]),
`ifdef KEY_CHORD_GLITCH_CNT_EN
      .glitch (glitch_vec[i]),
`endif
      .stb    (stb_vec[i])
    );
  end

  assign any_key = |stb_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      chord       <= '0;
      chord_valid <= 1'b0;
      last_sent   <= '0;
    end else begin
      state       <= state_next;
      chord       <= chord_next;
      chord_valid <= chord_valid_next;
      last_sent   <= last_sent_next;
    end
  end

  // While pending, chord tracks stb_vec so the consumer always takes the latest set
  always_comb begin
    state_next       = state;
    chord_next       = chord;
    chord_valid_next = chord_valid;
    last_sent_next   = last_sent;
    case (state)
      IDLE: begin
        if (stb_vec != last_sent) begin
          chord_next       = stb_vec;
          chord_valid_next = 1'b1;
          state_next       = PEND;
        end
      end
      PEND: begin
        chord_next = stb_vec;
        if (chord_valid && chord_ready) begin
          last_sent_next   = chord;
          chord_valid_next = 1'b0;
          state_next       = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef KEY_CHORD_GLITCH_CNT_EN
  localparam int unsigned GW = $clog2(N_KEYS + 1);

  logic [GW-1:0] glitch_pop;
  logic [16:0]   glitch_sum;

  // Several keys may discard an episode on the same edge; saturate at 0xFFFF
  always_comb begin
    glitch_pop = '0;
    for (int i = 0; i < int'(N_KEYS); i++) begin
      glitch_pop = glitch_pop + GW'(glitch_vec[i]);
    end
    glitch_sum = 17'(glitch_count) + 17'(glitch_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_count <= '0;
    end else begin
      glitch_count <= glitch_sum[16] ? 16'hFFFF : glitch_sum[15:0];
    end
  end
`endif

endmodule

// File: doc/key_chord_capture.md
# key_chord_capture

Front-end input stage of the piano datapath. Synchronises and debounces the eight raw key inputs and presents the resulting stable chord to the frequency/ROM/sum pipeline through a valid/ready handshake. A new chord word is offered only when the debounced key set changes. The consumer sees clean, glitch-free key bitmaps rather than raw switch inputs.

## Interface
Parameters:
- `N_KEYS`, 8, number of key inputs.
- `DEBOUNCE_CYCLES`, 50000, consecutive cycles a synchronised key must differ from its stable value before the stable value flips. Legal range is ≥ 2.

Ports:
- `clk`, in, 1, single clock. Everything is on its rising edge.
- `rst`, in, 1, reset. Synchronous, active-high.
- `keys`, in, `N_KEYS`, raw asynchronous key levels, with 1 meaning pressed. Bit ordering matches the chord word: `keys[7]` is key t0 and `keys[0]` is key t7.
- `chord`, out, `N_KEYS`, debounced chord offered to the consumer.
- `chord_valid`, out, 1, chord offer pending.
- `chord_ready`, in, 1, consumer accepts the offer.
- `any_key`, out, 1, OR of all debounced key states.
- `glitch_count`, out, 16, present only with `KEY_CHORD_GLITCH_CNT_EN`. Counts rejected glitches.

## Operation
- **Synchroniser**: each key passes through two flops, `s1` then `s2`.
- **Per-key debounce**, evaluated at each edge. `stb` is the stable value and `cnt` is a counter of width clog2(`DEBOUNCE_CYCLES`).
  - If `s2 == stb`: `cnt` <= 0.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stb` <= `s2` and `cnt` <= 0.
  - Else: `cnt` <= `cnt`+1.
  - Any return of `s2` to `stb` before the terminal count discards the episode.
- **Handshake FSM**, with states IDLE and PEND. A `last_sent` register holds the most recently transferred chord.
  - IDLE: if the stable vector `stb_vec != last_sent`, then `chord` <= `stb_vec`, `chord_valid` <= 1, and the FSM moves to PEND.
  - PEND: `chord` <= `stb_vec` every cycle, so the latest value wins while the offer is unaccepted.
  - PEND with `chord_valid & chord_ready` at an edge: transfer. `last_sent` <= `chord`, `chord_valid` <= 0, and the FSM moves to IDLE.
  - The value transferred is the `chord` visible in the cycle of the accepting edge.
  - If `stb_vec` has changed again after the transfer, IDLE re-offers it on the following edge.
- **Reverting change**: if `stb_vec` returns to `last_sent` while in PEND, the offer remains valid and carries that value. No retraction.
- **`chord_ready` in IDLE** is ignored.
- **`any_key`** is `|stb_vec`. It is registered implicitly because it derives from flops.

## Timing
- **Reset values**: `chord`=0, `chord_valid`=0, `any_key`=0, `glitch_count`=0. All `s1`, `s2`, `stb`, `cnt` and `last_sent` are 0, and the FSM is in IDLE.
- **Latency**: take the first edge sampling a new steady key level as edge 0. Then:
  - `s2` updates at edge 1.
  - `stb` updates at edge `DEBOUNCE_CYCLES`+1.
  - `chord_valid` rises after edge `DEBOUNCE_CYCLES`+2.
- **Throughput**: at most one transfer per two cycles, because IDLE costs one cycle after each transfer.
- **Simultaneous key changes** that settle on the same edge appear in one chord word.
- **Reset mid-operation**: any pending offer is dropped. After release, keys held through reset are debounced from zero and offered `DEBOUNCE_CYCLES`+2 edges after the first post-reset edge.

## Configuration
- **`KEY_CHORD_GLITCH_CNT_EN` defined**: `glitch_count` increments by the number of keys whose mismatch episode was discarded at that edge. It saturates at 0xFFFF and is cleared by `rst`.
- **Not defined**: the port and its logic are absent. Debounce behaviour is identical in both cases.

## Structure
- **Shared package `piano_pkg`**: holds `N_KEYS`, `chord_t` (logic [N_KEYS-1:0]) and the enum `cap_state_t` {IDLE, PEND}. The downstream frequency stage imports `chord_t` from it.
- **Sub-module `key_debounce_bit`**: a per-key synchroniser plus counter, instantiated `N_KEYS` times with a generate loop. It exports `stb` and a one-cycle `glitch` pulse.
- **Top level**: holds the FSM, `last_sent`, and the optional glitch counter.

## Test plan
All cases use `DEBOUNCE_CYCLES`=4.
- **Single clean press**: `keys`=0x80 held from edge 0 with `chord_ready`=1. `chord_valid`=1 with `chord`=0x80 after edge 6, the transfer happens at edge 7, and `any_key`=1.
- **Glitch rejection**: `keys`=0x01 for 3 cycles, then 0. `chord_valid` never rises, and `glitch_count`=1 when `KEY_CHORD_GLITCH_CNT_EN` is defined.
- **Latest wins under backpressure**: `chord_ready`=0, press 0x81, then add 0x02 once 0x81 is stable. `chord` moves 0x81→0x83 with `chord_valid` held high. With `chord_ready`=1, exactly one transfer of 0x83 occurs.
- **Release and re-offer**: after 0x83 is accepted, release all keys. An offer of 0x00 follows and `any_key`=0.
- **Reset mid-offer**: assert `rst` for 1 cycle while in PEND with 0x10 held. All outputs read 0 the cycle after, and 0x10 is re-offered after edge 6 counted from the first post-reset edge.
